// File: rtl/relax_pkg.sv
// Shared types and defaults for the edge-relaxation controller.
// Optional build macro: RELAX_INF_SAT_EN (all-ones distance = infinity).
package relax_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 128;
  localparam int DIST_W_DEF = 16;

  localparam logic [DIST_W_DEF-1:0] DIST_INF = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/relax_alu.sv
// Forwarding mux, candidate add and relax compare for stage 1.
// RELAX_INF_SAT_EN selects infinity-aware saturating arithmetic.
module relax_alu
  import relax_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [DIST_W-1:0] src_dist_i,
  input  logic [DATA_W-1:0] dst_word_i,
  input  logic [DIST_W-1:0] wt_i,
  input  logic              fwd_we_i,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  input  logic [DATA_W-1:0] fwd_word_i,
  output logic              relax_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic [DIST_W-1:0] src_dist;
  logic [DIST_W-1:0] dst_dist;
  logic [DIST_W-1:0] cand;
  logic [DATA_W-1:0] dst_word;
  logic [DIST_W:0]   sum;

  // The stage-2 write has not reached the SRAM yet, so bypass it here
  always_comb begin
    src_dist = src_dist_i;
    dst_word = dst_word_i;
    if (fwd_we_i && (fwd_addr_i == src_addr_i))
      src_dist = fwd_word_i[DIST_W-1:0];
    if (fwd_we_i && (fwd_addr_i == dst_addr_i))
      dst_word = fwd_word_i;
  end

  assign dst_dist = dst_word[DIST_W-1:0];
  assign sum      = {1'b0, src_dist} + {1'b0, wt_i};

`ifdef RELAX_INF_SAT_EN
  localparam logic [DIST_W-1:0] INF = {DIST_W{1'b1}};
  localparam logic [DIST_W-1:0] SAT = {INF[DIST_W-1:1], 1'b0};

  assign cand    = (sum >= {1'b0, INF}) ? SAT : sum[DIST_W-1:0];
  assign relax_o = (src_dist != INF) && (cand < dst_dist);
`else
  assign cand    = sum[DIST_W-1:0];
  assign relax_o = sum < {1'b0, dst_dist};
`endif

  assign wdata_o = {dst_word[DATA_W-1:DIST_W], cand};

endmodule

// File: rtl/relax_ctrl.sv
// Single-pass edge relaxation controller: FSM plus two-stage pipeline.
// Optional build macro: RELAX_INF_SAT_EN (see relax_alu).
module relax_ctrl
  import relax_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic [ADDR_W-1:0] edge_src,
  input  logic [ADDR_W-1:0] edge_dst,
  input  logic [DIST_W-1:0] edge_wt,
  input  logic              edge_last,
  output logic [ADDR_W-1:0] ReadAddress1,
  output logic [ADDR_W-1:0] ReadAddress2,
  input  logic [DATA_W-1:0] ReadBus1,
  input  logic [DATA_W-1:0] ReadBus2,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteBus,
  output logic              busy,
  output logic              done,
  output logic              changed,
  output logic [ADDR_W:0]   update_count
);

  state_e state_q, state_d;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] ra1_q, ra2_q;
  logic [DIST_W-1:0] wt_q;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wb_q;
  logic              changed_q, changed_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              fire;
  logic              start_acc;
  logic              relax;
  logic              relax_fire;
  logic [DATA_W-1:0] wdata;
  logic              unused_rb1;

  assign unused_rb1 = ^ReadBus1[DATA_W-1:DIST_W];

  assign edge_ready = (state_q == ST_RUN);
  assign fire       = edge_valid && edge_ready;
  assign start_acc  = (state_q == ST_IDLE) && start;
  assign relax_fire = s1_valid_q && relax;

  relax_alu #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DIST_W(DIST_W)
  ) u_alu (
    .src_addr_i(ra1_q),
    .dst_addr_i(ra2_q),
    .src_dist_i(ReadBus1[DIST_W-1:0]),
    .dst_word_i(ReadBus2),
    .wt_i      (wt_q),
    .fwd_we_i  (we_q),
    .fwd_addr_i(wa_q),
    .fwd_word_i(wb_q),
    .relax_o   (relax),
    .wdata_o   (wdata)
  );

  // DRAIN admits no edges, so stage 1 is empty after exactly one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (fire && edge_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    changed_d = changed_q;
    cnt_d     = cnt_q;
    if (start_acc) begin
      changed_d = 1'b0;
      cnt_d     = '0;
    end else if (relax_fire) begin
      changed_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wt_q       <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wb_q       <= '0;
      changed_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= fire;
      if (fire) begin
        ra1_q <= edge_src;
        ra2_q <= edge_dst;
        wt_q  <= edge_wt;
      end
      we_q <= relax_fire;
      if (relax_fire) begin
        wa_q <= ra2_q;
        wb_q <= wdata;
      end
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ReadAddress1 = ra1_q;
  assign ReadAddress2 = ra2_q;
  assign WE           = we_q;
  assign WriteAddress = wa_q;
  assign WriteBus     = wb_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign changed      = changed_q;
  assign update_count = cnt_q;

endmodule
